memory_access: RTL

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// memory_access -- load/store stage between execute and writeback.
//
// Accepts one execute-stage result at a time. NONE operations pass the
// result straight to writeback; loads and stores run a request/ack handshake
// against a 32-bit data memory, with byte/halfword lane steering on both
// paths. Stores complete with out_rd = 0 so they never write a register.
//
// Ports:
//   clk, reset               single clock, synchronous active-high reset
//   in_valid / in_ready      operation handshake from execute
//   result                   effective address or passthrough value
//   store_data               store source register value
//   mem_op                   operation code (unlisted codes behave as NONE)
//   rd                       destination register index
//   mem_req / mem_we         memory request and write enable
//   mem_addr                 word-aligned memory address
//   mem_wdata / mem_wstrb    lane-replicated store data and byte enables
//   mem_ack / mem_rdata      memory completion and read data
//   out_valid / out_data /   one-cycle writeback pulse
//   out_rd
//   misaligned               misaligned-access flag (MEM_MISALIGN_CHECK_EN only)
//
// Configuration:
//   MEM_MISALIGN_CHECK_EN    when defined, misaligned halfword/word accesses
//                            are rejected without a memory request and
//                            flagged on the misaligned port. When undefined,
//                            the low address bits are simply ignored.

module memory_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] result,
  input  logic [31:0] store_data,
  input  logic [3:0]  mem_op,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state;

  // Operation context latched on acceptance and used when the ack returns.
  logic [4:0]  rd_q;
  logic [1:0]  addr_lo_q;
  size_t       size_q;
  logic        sign_q;
  logic        is_load_q;

  // Decode of the incoming operation.
  logic        is_load_in;
  logic        is_store_in;
  size_t       size_in;
  logic        sign_in;

  // Store lane steering of the incoming operation.
  logic [31:0] wdata_in;
  logic [3:0]  wstrb_in;

  // Load lane extraction from the returning read data.
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_val;

  assign in_ready = (state == IDLE);

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the case statements can leave it unassigned and infer
  // a latch.
  always_comb begin
    is_load_in  = 1'b0;
    is_store_in = 1'b0;
    size_in     = SZ_W;
    sign_in     = 1'b0;
    case (mem_op)
      OP_LB:   begin is_load_in  = 1'b1; size_in = SZ_B; sign_in = 1'b1; end
      OP_LH:   begin is_load_in  = 1'b1; size_in = SZ_H; sign_in = 1'b1; end
      OP_LW:   begin is_load_in  = 1'b1; size_in = SZ_W; end
      OP_LBU:  begin is_load_in  = 1'b1; size_in = SZ_B; end
      OP_LHU:  begin is_load_in  = 1'b1; size_in = SZ_H; end
      OP_SB:   begin is_store_in = 1'b1; size_in = SZ_B; end
      OP_SH:   begin is_store_in = 1'b1; size_in = SZ_H; end
      OP_SW:   begin is_store_in = 1'b1; size_in = SZ_W; end
      default: ;
    endcase
  end

  // Store data is replicated across every lane so the byte enables alone
  // select where it lands in memory.
  always_comb begin
    wdata_in = store_data;
    wstrb_in = 4'b1111;
    case (size_in)
      SZ_B: begin
        wdata_in = {4{store_data[7:0]}};
        wstrb_in = 4'b0001 << result[1:0];
      end
      SZ_H: begin
        wdata_in = {2{store_data[15:0]}};
        wstrb_in = result[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    load_byte = mem_rdata[7:0];
    case (addr_lo_q)
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      2'd3:    load_byte = mem_rdata[31:24];
      default: ;
    endcase
    load_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val  = mem_rdata;
    case (size_q)
      SZ_B:    load_val = sign_q ? {{24{load_byte[7]}}, load_byte}
                                 : {24'h000000, load_byte};
      SZ_H:    load_val = sign_q ? {{16{load_half[15]}}, load_half}
                                 : {16'h0000, load_half};
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_in;
  assign misalign_in = (is_load_in || is_store_in) &&
                       (((size_in == SZ_H) && result[0]) ||
                        ((size_in == SZ_W) && (result[1:0] != 2'b00)));
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'h0;
      out_valid  <= 1'b0;
      out_data   <= 32'h0;
      out_rd     <= 5'h0;
      rd_q       <= 5'h0;
      addr_lo_q  <= 2'b00;
      size_q     <= SZ_W;
      sign_q     <= 1'b0;
      is_load_q  <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misaligned <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rd_q      <= rd;
            addr_lo_q <= result[1:0];
            size_q    <= size_in;
            sign_q    <= sign_in;
            is_load_q <= is_load_in;
`ifdef MEM_MISALIGN_CHECK_EN
            if (misalign_in) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_data   <= 32'h0;
              out_rd     <= 5'h0;
              misaligned <= 1'b1;
            end else
`endif
            if (is_load_in || is_store_in) begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= is_store_in;
              mem_addr  <= {result[31:2], 2'b00};
              mem_wdata <= is_store_in ? wdata_in : 32'h0;
              mem_wstrb <= is_store_in ? wstrb_in : 4'h0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= result;
              out_rd    <= rd;
            end
          end
        end

        // Address, data and strobes are held untouched until the ack.
        ACCESS: begin
          if (mem_ack) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'h0;
            out_valid <= 1'b1;
            out_data  <= is_load_q ? load_val : 32'h0;
            out_rd    <= is_load_q ? rd_q : 5'h0;
          end
        end

        DONE: begin
          state      <= IDLE;
          out_valid  <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
          misaligned <= 1'b0;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
